if_fetch: RTL
=============

// Module: if_fetch
// PURPOSE
//  Instruction-fetch stage directly downstream of the PC register. Takes the current fetch PC, runs a
//  req/ack transaction on the instruction-memory port, and registers {pc, inst, valid} toward IF/ID.
//  Drives fetch_busy_o to the pipeline controller so the PC register holds while a fetch is in flight.
//  Honours pipeline stall and flush (exception redirect) and discards responses made stale by a flush.
// PARAMETERS
//  ADDR_W    32        fetch address width
//  DATA_W    32        instruction width
//  NOP_INST  32'h0     instruction emitted on reset/flush/bubble (sll $0,$0,0)
// PORTS
//  clk            in   1       single clock, all state on posedge
//  rst            in   1       synchronous, active-high reset (`RstEnable == 1'b1)
//  pc_i           in   ADDR_W  fetch address from PC register
//  stall_i        in   1       IF/ID hold request from controller (1 = hold outputs)
//  flush_i        in   1       pipeline flush (exception/interrupt redirect)
//  imem_req_o     out  1       memory request, level, held until ack
//  imem_addr_o    out  ADDR_W  request address, stable while imem_req_o=1
//  imem_ack_i     in   1       one-cycle response strobe, qualifies imem_rdata_i
//  imem_rdata_i   in   DATA_W  returned instruction
//  if_pc_o        out  ADDR_W  PC of instruction presented to IF/ID
//  if_inst_o      out  DATA_W  instruction presented to IF/ID
//  if_valid_o     out  1       if_inst_o is real (0 = bubble)
//  fetch_busy_o   out  1       stall request to controller; 1 while a fetch is outstanding or buffered
// BEHAVIOUR
//  - Reset: FSM=IDLE; imem_req_o=0, imem_addr_o=0, if_pc_o=0, if_inst_o=NOP_INST, if_valid_o=0,
//    fetch_busy_o=0; skid entry invalid. Reset mid-transaction abandons it; imem must tolerate req drop.
//  - FSM IDLE: if !flush_i and skid empty -> latch pc_i into imem_addr_o, req=1, go WAIT.
//    WAIT: req held; on ack -> deliver/capture response, req=0, go IDLE; on flush_i without ack -> DROP.
//    DROP: req held (transaction must complete); on ack discard data, go IDLE. No output update.
//  - Min latency: request issued the cycle after pc_i is valid; zero-wait ack gives if_valid_o=1
//    two posedges after pc_i presented. Back-to-back fetches every 2 cycles with zero-wait memory.
//  - Delivery on ack in WAIT: if !stall_i -> if_pc_o<=imem_addr_o, if_inst_o<=rdata, if_valid_o<=1.
//    If stall_i=1 -> response into 1-entry skid; outputs untouched; drained on first cycle stall_i=0.
//  - stall_i=1 with nothing arriving: all if_* outputs hold. Stall never cancels an outstanding req.
//  - Not stalled and nothing to deliver: if_valid_o<=0, if_inst_o<=NOP_INST (bubble).
//  - fetch_busy_o = (state!=IDLE) | skid_valid, combinational from registers only (no input path).
//  - flush_i (highest priority after rst): same edge if_valid_o<=0, if_inst_o<=NOP_INST, skid cleared;
//    WAIT->DROP; flush+ack same cycle in WAIT -> data dropped, IDLE. New PC fetched from IDLE next cycle.
//  - flush_i and stall_i both 1: flush wins.
//  - Address increment/wrap is the PC register's job; this block never modifies the address.
// CONFIGURATION
//  `FETCH_ALIGN_CHECK_EN defined: pc_i[1:0]!=0 in IDLE issues no request; block delivers one
//   bubble with extra output if_adel_o=1 (address-error-load flag to exception logic) and
//   if_pc_o=pc_i; if_adel_o cleared by next delivery, flush or reset (reset 0).
//  Undefined: no alignment check, port if_adel_o absent, pc_i[1:0] passed to memory unchanged.
// STRUCTURE
//  Shared defines file: FSM encodings IF_IDLE/IF_WAIT/IF_DROP, NOP_INST, existing RstEnable/Stall/FLUSH.
//  One sub-module: if_skid_buf (1-entry {pc,inst} buffer with load/drain/clear, valid flag).
// TESTING
//  1 rst=1 for 3 cycles with imem_ack_i=1 -> all outputs at reset values, imem_req_o=0.
//  2 pc_i=0x00000000, zero-wait ack, rdata=0x3C011234 -> req 1 cycle later; next edge if_pc_o=0,
//    if_inst_o=0x3C011234, if_valid_o=1; fetch_busy_o=1 only while WAIT.
//  3 3-cycle ack latency on pc_i=0x4 -> imem_addr_o stable 0x4 with req=1 for 3 cycles; busy=1 throughout.
//  4 ack arrives with stall_i=1 -> outputs hold old value, busy stays 1; stall_i drop -> buffered inst
//    appears next edge, busy=0.
//  5 flush_i pulse 1 cycle after req, ack 2 cycles later with 0xDEADBEEF -> if_valid_o=0, 0xDEADBEEF
//    never appears; new fetch of pc_i=0x80000180 delivered afterwards.
//  6 (FETCH_ALIGN_CHECK_EN) pc_i=0x00000006 -> no imem_req_o, if_adel_o=1, if_valid_o=0, if_pc_o=0x6.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, bubble instruction,
// and control-level constants used across the fetch slice.
package if_fetch_pkg;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_WAIT = 2'd1,
    IF_DROP = 2'd2
  } if_state_e;

  localparam logic [31:0] IF_NOP_INST = 32'h0000_0000;  // sll $0,$0,0
  localparam logic        RstEnable   = 1'b1;
  localparam logic        StallEnable = 1'b1;
  localparam logic        FlushEnable = 1'b1;

endpackage

// File: rtl/if_fetch_skid_buf.sv
// One-entry {pc, inst} holding buffer for a response that arrives while IF/ID is stalled.
// Clear dominates load, load dominates drain.
module if_skid_buf
  import if_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_drain,
  input  logic              i_clear,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [DATA_W-1:0] i_inst,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_pc,
  output logic [DATA_W-1:0] o_inst
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_inst;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_inst  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_inst  <= i_inst;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_inst  = r_inst;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: req/ack fetch from imem, registered {pc, inst, valid} toward IF/ID.
// Optional FETCH_ALIGN_CHECK_EN adds a misaligned-PC check and the if_adel_o flag.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(IF_NOP_INST)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [DATA_W-1:0] if_inst_o,
  output logic              if_valid_o,
  output logic              fetch_busy_o
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic              if_adel_o
`endif
);

  if_state_e         r_state;
  if_state_e         w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_if_pc;
  logic [DATA_W-1:0] r_if_inst;
  logic              r_if_valid;
  logic              w_issue;
  logic              w_resp;
  logic              w_adel_evt;
  logic              w_misalign;
  logic              w_stall;
  logic              w_flush;
  logic              w_skid_valid;
  logic [ADDR_W-1:0] w_skid_pc;
  logic [DATA_W-1:0] w_skid_inst;

  assign w_stall = (stall_i == StallEnable);
  assign w_flush = (flush_i == FlushEnable);

`ifdef FETCH_ALIGN_CHECK_EN
  assign w_misalign = (pc_i[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst == RstEnable) r_state <= IF_IDLE;
    else                  r_state <= w_state_nxt;
  end

  // A flushed request stays on the bus until acked; its data is discarded in DROP.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_resp      = 1'b0;
    w_adel_evt  = 1'b0;
    unique case (r_state)
      IF_IDLE: begin
        if (!w_flush && !w_skid_valid) begin
          if (w_misalign) begin
            w_adel_evt = 1'b1;
          end else begin
            w_issue     = 1'b1;
            w_state_nxt = IF_WAIT;
          end
        end
      end
      IF_WAIT: begin
        if (w_flush) begin
          w_state_nxt = imem_ack_i ? IF_IDLE : IF_DROP;
        end else if (imem_ack_i) begin
          w_resp      = 1'b1;
          w_state_nxt = IF_IDLE;
        end
      end
      IF_DROP: begin
        if (imem_ack_i) w_state_nxt = IF_IDLE;
      end
      default: w_state_nxt = IF_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) r_addr <= '0;
    else if (w_issue)     r_addr <= pc_i;
  end

  if_skid_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_resp && w_stall),
    .i_drain (w_skid_valid && !w_stall),
    .i_clear (w_flush),
    .i_pc    (r_addr),
    .i_inst  (imem_rdata_i),
    .o_valid (w_skid_valid),
    .o_pc    (w_skid_pc),
    .o_inst  (w_skid_inst)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_if_pc    <= '0;
      r_if_inst  <= NOP_INST;
      r_if_valid <= 1'b0;
    end else if (w_flush) begin
      r_if_inst  <= NOP_INST;
      r_if_valid <= 1'b0;
    end else if (!w_stall) begin
      if (w_resp) begin
        r_if_pc    <= r_addr;
        r_if_inst  <= imem_rdata_i;
        r_if_valid <= 1'b1;
      end else if (w_skid_valid) begin
        r_if_pc    <= w_skid_pc;
        r_if_inst  <= w_skid_inst;
        r_if_valid <= 1'b1;
      end else begin
        if (w_adel_evt) r_if_pc <= pc_i;
        r_if_inst  <= NOP_INST;
        r_if_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_adel;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_adel <= 1'b0;
    end else if (w_flush) begin
      r_adel <= 1'b0;
    end else if (!w_stall) begin
      if (w_resp || w_skid_valid) r_adel <= 1'b0;
      else if (w_adel_evt)        r_adel <= 1'b1;
    end
  end

  assign if_adel_o = r_adel;
`endif

  assign imem_req_o   = (r_state != IF_IDLE);
  assign imem_addr_o  = r_addr;
  assign if_pc_o      = r_if_pc;
  assign if_inst_o    = r_if_inst;
  assign if_valid_o   = r_if_valid;
  assign fetch_busy_o = (r_state != IF_IDLE) || w_skid_valid;

endmodule
